univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//  Parametrised universal shift register: hold, parallel load, shift left/right, rotate left/right.
//  Adds a burst engine that applies one shift/rotate op N times autonomously, with busy/done handshake.
//  Next generation of the team's 4-bit load/shift register; used as the serializer/deserializer core.
// PARAMETERS
//  WIDTH   4   register width in bits (>=2)
//  CNT_W   3   width of burst count; max burst = 2**CNT_W-1 steps
// PORTS
//  clk        in   1        rising-edge clock; the only clock
//  reset_n    in   1        asynchronous, active-low reset
//  d          in   WIDTH    parallel load data
//  mode       in   3        op select (see BEHAVIOUR)
//  ser_lsb    in   1        serial in for shift left (enters bit 0)
//  ser_msb    in   1        serial in for shift right (enters bit WIDTH-1)
//  start      in   1        burst request, sampled only in IDLE
//  count      in   CNT_W    burst length, sampled with start
//  q          out  WIDTH    register contents (registered)
//  busy       out  1        high while burst RUN in progress
//  done       out  1        one-cycle pulse when burst completes
//  parity     out  1        only with SHIFT_REG_PARITY_EN
// BEHAVIOUR
//  Reset (reset_n=0, async, any state): q=0, busy=0, done=0, FSM->IDLE, step counter=0.
//  mode: 000 hold; 001 load q<=d; 010 SHL q<={q[W-2:0],ser_lsb}; 011 SHR q<={ser_msb,q[W-1:1]};
//        100 ROL q<={q[W-2:0],q[W-1]}; 101 ROR q<={q[0],q[W-1:1]}; 110/111 hold.
//  FSM states IDLE, RUN, DONE.
//  IDLE, start=0: mode applied every clock edge, result visible on q the next cycle (1-cycle latency).
//  IDLE, start=1, mode in {010..101}, count>0: latch mode+count, do NOT apply op this edge; ->RUN, busy=1.
//  IDLE, start=1, count=0 or mode not a shift/rotate: q unchanged, ->DONE (done pulse, no shifting).
//  RUN: apply latched op each cycle; mode/start/d ignored; ser_lsb/ser_msb sampled live each step.
//   After exactly count steps ->DONE; busy falls the same edge done rises.
//  DONE: done=1 one cycle, q held, busy=0; ->IDLE. start in DONE is ignored.
//  Total burst: start edge + count step cycles + 1 done cycle; next start accepted the cycle after done.
//  Reset mid-burst aborts immediately; no done pulse.
//  All arithmetic unsigned; step counter CNT_W bits, never wraps (terminates at count).
// CONFIGURATION
//  SHIFT_REG_PARITY_EN defined: port parity present, parity = ^q (even-parity bit, combinational from q),
//   0 in reset.
//  Not defined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  Package shift_reg_pkg: mode encodings (MODE_HOLD..MODE_ROR), FSM state encodings (ST_IDLE/RUN/DONE).
//  Sub-module shift_reg_next: combinational next-q function (q, d, mode, ser_lsb, ser_msb) -> q_next;
//   shared by direct and burst paths. Top holds q register, FSM, step counter.
// TESTING (WIDTH=4, CNT_W=3)
//  Reset: reset_n=0 mid-burst with q=1011 -> q=0000, busy=0, done=0 asynchronously, no done pulse.
//  Direct ops: load 1101; SHL ser_lsb=1 -> 1011; SHR ser_msb=0 -> 0101; ROL -> 1010; ROR -> 0101; 110 -> hold.
//  Burst: q=0001, start mode=ROL count=3 -> busy 3 cycles, q 0010,0100,1000, then done=1 one cycle, busy=0.
//  Burst ignores inputs: during RUN drive mode=load d=1111, start=1 -> no effect on sequence or restart.
//  Zero/invalid burst: start count=0 or mode=load -> no busy, done pulse next cycle, q unchanged.
//  Serial burst: q=0000, SHL count=4, ser_lsb=1,1,0,1 per step -> q=1101 at done; parity (if EN)=1.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// ============================================================================
//  Module      : shift_reg_pkg
//  Description : Shared encodings for the universal shift register: operation
//                select codes, burst FSM states and a burst-op classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_reg_pkg;

  // Operation select codes; 3'b110 and 3'b111 behave as hold
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;

  // Burst engine states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Only the four shift/rotate ops may be repeated by the burst engine
  function automatic logic is_burst_op(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) ||
           (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_reg_next.sv
// ============================================================================
//  Module      : shift_reg_next
//  Description : Combinational next-state function of the shift register.
//                Shared by the direct (per-clock) path and the burst engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_next
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [2:0]       mode_i,
  input  logic             ser_lsb_i,
  input  logic             ser_msb_i,
  output logic [WIDTH-1:0] q_next_o
);

  // Select the new register value for the requested operation
  always_comb begin
    q_next_o = q_i;
    case (mode_i)
      MODE_LOAD: q_next_o = d_i;
      MODE_SHL:  q_next_o = {q_i[WIDTH-2:0], ser_lsb_i};
      MODE_SHR:  q_next_o = {ser_msb_i, q_i[WIDTH-1:1]};
      MODE_ROL:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ROR:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
      default:   q_next_o = q_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/univ_shift_reg.sv
// ============================================================================
//  Module      : univ_shift_reg
//  Description : Parametrised universal shift register (hold, load, shift
//                left/right, rotate left/right) with a burst engine that
//                repeats one shift/rotate op COUNT times, reporting busy/done.
//                Optional macro SHIFT_REG_PARITY_EN adds an even-parity output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic [2:0]       mode,
  input  logic             ser_lsb,
  input  logic             ser_msb,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
`ifdef SHIFT_REG_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [CNT_W-1:0] c_cnt_zero = '0;
  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [2:0]       w_eff_mode;

  shift_reg_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .q_i       (q_q),
    .d_i       (d),
    .mode_i    (w_eff_mode),
    .ser_lsb_i (ser_lsb),
    .ser_msb_i (ser_msb),
    .q_next_o  (q_d)
  );

  // Burst FSM: decides which op reaches the datapath and tracks step count
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    len_d      = len_q;
    op_d       = op_q;
    w_eff_mode = MODE_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // The start edge itself never changes q
          if ((count != c_cnt_zero) && is_burst_op(mode)) begin
            len_d   = count;
            op_d    = mode;
            step_d  = c_cnt_zero;
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          w_eff_mode = mode;
        end
      end
      ST_RUN: begin
        // step_q+1 never exceeds len_q, so the counter cannot wrap
        w_eff_mode = op_q;
        step_d     = step_q + c_cnt_one;
        if (step_d == len_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and data register with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      len_q   <= '0;
      op_q    <= MODE_HOLD;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      op_q    <= op_d;
      q_q     <= q_d;
    end
  end

  assign q    = q_q;
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

`ifdef SHIFT_REG_PARITY_EN
  assign parity = ^q_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// ============================================================================
//  Module      : tb_univ_shift_reg
//  Description : Self-checking bench for univ_shift_reg (WIDTH=4, CNT_W=3).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_univ_shift_reg;

  localparam int W    = 4;
  localparam int CW   = 3;
  localparam int MASK = (1 << W) - 1;

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  d;
  logic [2:0]    mode;
  logic          ser_lsb;
  logic          ser_msb;
  logic          start;
  logic [CW-1:0] count;
  logic [W-1:0]  q;
  logic          busy;
  logic          done;
`ifdef SHIFT_REG_PARITY_EN
  logic          parity;
`endif

  int checks   = 0;
  int failures = 0;

  univ_shift_reg #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (d),
    .mode    (mode),
    .ser_lsb (ser_lsb),
    .ser_msb (ser_msb),
    .start   (start),
    .count   (count),
    .q       (q),
    .busy    (busy),
    .done    (done)
`ifdef SHIFT_REG_PARITY_EN
    ,
    .parity  (parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]    mode;
    logic [W-1:0]  d;
    logic          sl;
    logic          sm;
    logic          st;
    logic [CW-1:0] cnt;
    logic [W-1:0]  eq;
    logic          eb;
    logic          ed;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [2:0] m, input logic [W-1:0] dd,
                              input logic sl, input logic sm, input logic st,
                              input logic [CW-1:0] c, input logic [W-1:0] eq,
                              input logic eb, input logic ed);
    vec_t v;
    v.mode = m; v.d = dd; v.sl = sl; v.sm = sm; v.st = st; v.cnt = c;
    v.eq = eq; v.eb = eb; v.ed = ed;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] m, input logic [W-1:0] dd,
                       input logic sl, input logic sm, input logic st,
                       input logic [CW-1:0] c);
    mode = m; d = dd; ser_lsb = sl; ser_msb = sm; start = st; count = c;
  endtask

  // Advance one rising edge, then land on the falling edge for sampling
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: register value plus "steps remaining" burst bookkeeping
  int m_q, m_rem, m_op;
  bit m_done;

  function automatic int apply_op(input int op, input int qq, input int dd,
                                  input int sl, input int sm);
    case (op)
      1:       return dd & MASK;
      2:       return ((qq * 2) + sl) & MASK;
      3:       return (qq / 2) + sm * (1 << (W - 1));
      4:       return ((qq * 2) & MASK) + (qq / (1 << (W - 1)));
      5:       return (qq / 2) + (qq % 2) * (1 << (W - 1));
      default: return qq;
    endcase
  endfunction

  function automatic void model_step(input int mm, input int dd, input int sl,
                                     input int sm, input int st, input int c);
    if (m_rem > 0) begin
      m_q = apply_op(m_op, m_q, dd, sl, sm);
      m_rem--;
      if (m_rem == 0) m_done = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (st != 0) begin
      if (c > 0 && mm >= 2 && mm <= 5) begin
        m_rem = c;
        m_op  = mm;
      end else begin
        m_done = 1;
      end
    end else begin
      m_q = apply_op(mm, m_q, dd, sl, sm);
    end
  endfunction

  logic [3:0] ser_bits;
  logic [3:0] ser_exp;

  initial begin
    reset_n = 1'b0;
    drive(3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    tick();
    check("reset_q", q, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
`ifdef SHIFT_REG_PARITY_EN
    check("reset_parity", parity, 0);
`endif
    reset_n = 1'b1;

    // ------------------------------------------------------------ table
    add(3'b001, 4'b1101, 0, 0, 0, 0, 4'b1101, 0, 0);
    add(3'b010, 4'b0000, 1, 0, 0, 0, 4'b1011, 0, 0);
    add(3'b011, 4'b0000, 0, 0, 0, 0, 4'b0101, 0, 0);
    add(3'b100, 4'b0000, 0, 0, 0, 0, 4'b1010, 0, 0);
    add(3'b101, 4'b0000, 0, 0, 0, 0, 4'b0101, 0, 0);
    add(3'b110, 4'b1111, 1, 1, 0, 0, 4'b0101, 0, 0);
    add(3'b111, 4'b1111, 1, 1, 0, 0, 4'b0101, 0, 0);
    add(3'b000, 4'b1111, 1, 1, 0, 0, 4'b0101, 0, 0);
    add(3'b011, 4'b0000, 0, 1, 0, 0, 4'b1010, 0, 0);
    // ROL burst of 3 with load/start noise during RUN and DONE
    add(3'b001, 4'b0001, 0, 0, 0, 0, 4'b0001, 0, 0);
    add(3'b100, 4'b0000, 0, 0, 1, 3, 4'b0001, 1, 0);
    add(3'b001, 4'b1111, 1, 1, 1, 7, 4'b0010, 1, 0);
    add(3'b001, 4'b1111, 1, 1, 1, 7, 4'b0100, 1, 0);
    add(3'b001, 4'b1111, 1, 1, 1, 7, 4'b1000, 0, 1);
    add(3'b001, 4'b1111, 1, 1, 1, 7, 4'b1000, 0, 0);
    add(3'b000, 4'b0000, 0, 0, 0, 0, 4'b1000, 0, 0);
    // zero-length and invalid-op bursts
    add(3'b100, 4'b0000, 0, 0, 1, 0, 4'b1000, 0, 1);
    add(3'b000, 4'b0000, 0, 0, 0, 0, 4'b1000, 0, 0);
    add(3'b001, 4'b1111, 0, 0, 1, 3, 4'b1000, 0, 1);
    add(3'b000, 4'b0000, 0, 0, 0, 0, 4'b1000, 0, 0);
    // maximum-length SHR burst with ser_msb=1
    add(3'b011, 4'b0000, 0, 1, 1, 7, 4'b1000, 1, 0);
    add(3'b000, 4'b0000, 0, 1, 0, 0, 4'b1100, 1, 0);
    add(3'b000, 4'b0000, 0, 1, 0, 0, 4'b1110, 1, 0);
    add(3'b000, 4'b0000, 0, 1, 0, 0, 4'b1111, 1, 0);
    add(3'b000, 4'b0000, 0, 1, 0, 0, 4'b1111, 1, 0);
    add(3'b000, 4'b0000, 0, 1, 0, 0, 4'b1111, 1, 0);
    add(3'b000, 4'b0000, 0, 1, 0, 0, 4'b1111, 1, 0);
    add(3'b000, 4'b0000, 0, 1, 0, 0, 4'b1111, 0, 1);
    add(3'b000, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].mode, vecs[i].d, vecs[i].sl, vecs[i].sm, vecs[i].st,
            vecs[i].cnt);
      tick();
      check($sformatf("vec%0d_q", i), q, vecs[i].eq);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].eb);
      check($sformatf("vec%0d_done", i), done, vecs[i].ed);
    end

    // ------------------------------------------------ serial SHL burst
    drive(3'b001, 4'b0000, 0, 0, 0, 0);
    tick();
    drive(3'b010, 4'b0000, 0, 0, 1, 4);
    tick();
    check("ser_start_busy", busy, 1);
    ser_bits = 4'b1011;  // bit k is ser_lsb for step k: 1,1,0,1
    ser_exp  = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      drive(3'b001, 4'b1111, ser_bits[k], 0, 1, 7);
      tick();
      ser_exp = {ser_exp[2:0], ser_bits[k]};
      check($sformatf("ser_step%0d_q", k), q, ser_exp);
    end
    check("ser_final_q", q, 4'b1101);
    check("ser_final_done", done, 1);
    check("ser_final_busy", busy, 0);
`ifdef SHIFT_REG_PARITY_EN
    check("ser_parity", parity, 1);
`endif
    drive(3'b000, 4'b0000, 0, 0, 0, 0);
    tick();
    check("ser_after_done", done, 0);

    // ------------------------------------------- reset in the middle of RUN
    drive(3'b001, 4'b1011, 0, 0, 0, 0);
    tick();
    drive(3'b100, 4'b0000, 0, 0, 1, 5);
    tick();
    check("rst_pre_q", q, 4'b1011);
    check("rst_pre_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_q", q, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_done", done, 0);
    drive(3'b000, 4'b0000, 0, 0, 0, 0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check($sformatf("rst_nodone%0d", k), done, 0);
      check($sformatf("rst_noq%0d", k), q, 0);
    end

    // ------------------------------------------------ randomized vs model
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_q = 0; m_rem = 0; m_op = 0; m_done = 0;
    for (int n = 0; n < 600; n++) begin
      drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, MASK)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)));
      model_step(int'(mode), int'(d), int'(ser_lsb), int'(ser_msb),
                 int'(start), int'(count));
      tick();
      check($sformatf("rnd%0d_q", n), q, m_q);
      check($sformatf("rnd%0d_busy", n), busy, (m_rem > 0) ? 1 : 0);
      check($sformatf("rnd%0d_done", n), done, m_done ? 1 : 0);
`ifdef SHIFT_REG_PARITY_EN
      check($sformatf("rnd%0d_parity", n), parity, $countones(m_q) % 2);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
